// File: rtl/cordic_pkg.sv
// Shared types for the CORDIC quadrant front end: controller states and the
// quadrant index carried alongside each request.
package cordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_BUSY   = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    Q1 = 2'd0,
    Q2 = 2'd1,
    Q3 = 2'd2,
    Q4 = 2'd3
  } quadrant_t;

endpackage

// File: rtl/cordic_quadrant_fold.sv
// Maps first-quadrant magnitudes (cos f, sin f) onto the full circle by
// rotating the vector through q quarter turns.
module cordic_quadrant_fold
  import cordic_pkg::*;
#(
  parameter int BW = 8
) (
  input  logic [1:0]    q,
  input  logic [BW-1:0] x,
  input  logic [BW-1:0] y,
  output logic [BW:0]   cos,
  output logic [BW:0]   sin
);

  logic [BW:0] x_pos;
  logic [BW:0] y_pos;
  logic [BW:0] x_neg;
  logic [BW:0] y_neg;

  // One extra bit of headroom makes every negation exact, and -0 wraps to 0.
  assign x_pos = {1'b0, x};
  assign y_pos = {1'b0, y};
  assign x_neg = -x_pos;
  assign y_neg = -y_pos;

  always_comb begin
    cos = x_pos;
    sin = y_pos;
    case (quadrant_t'(q))
      Q1: begin cos = x_pos; sin = y_pos; end
      Q2: begin cos = y_neg; sin = x_pos; end
      Q3: begin cos = x_neg; sin = y_neg; end
      Q4: begin cos = y_pos; sin = x_neg; end
      default: begin cos = x_pos; sin = y_pos; end
    endcase
  end

endmodule

// File: rtl/cordic_quadrant_frontend.sv
// Full-circle wrapper around a quadrant-I CORDIC core: splits the angle,
// launches the core, folds its result back into the right quadrant.
module cordic_quadrant_frontend
  import cordic_pkg::*;
#(
  parameter int BIT_WIDTH = 8,
  parameter int K_UNUSED  = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH+1:0] in_angle,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH:0]   out_cos,
  output logic [BIT_WIDTH:0]   out_sin,
  output logic                 cordic_start,
  output logic [BIT_WIDTH-1:0] cordic_angle,
  input  logic                 cordic_done,
  input  logic [BIT_WIDTH-1:0] cordic_x,
  input  logic [BIT_WIDTH-1:0] cordic_y
);

  logic [31:0] k_unused_w;
  assign k_unused_w = 32'(K_UNUSED);

  state_t               state_q;
  quadrant_t            quad_q;
  logic [BIT_WIDTH-1:0] angle_q;
  logic [BIT_WIDTH:0]   cos_q;
  logic [BIT_WIDTH:0]   sin_q;
  logic                 start_q;
  logic                 valid_q;
  logic [BIT_WIDTH:0]   cos_d;
  logic [BIT_WIDTH:0]   sin_d;

  cordic_quadrant_fold #(.BW(BIT_WIDTH)) u_fold (
    .q   (quad_q),
    .x   (cordic_x),
    .y   (cordic_y),
    .cos (cos_d),
    .sin (sin_d)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      quad_q  <= Q1;
      angle_q <= '0;
      cos_q   <= '0;
      sin_q   <= '0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid && cordic_done) begin
            quad_q  <= quadrant_t'(in_angle[BIT_WIDTH+1:BIT_WIDTH]);
            angle_q <= in_angle[BIT_WIDTH-1:0];
            start_q <= 1'b1;
            state_q <= ST_LAUNCH;
          end
        end
        // Hold start until the core acknowledges by dropping done.
        ST_LAUNCH: begin
          if (!cordic_done) begin
            start_q <= 1'b0;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cordic_done) begin
            cos_q   <= cos_d;
            sin_q   <= sin_d;
            valid_q <= 1'b1;
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          start_q <= 1'b0;
          valid_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready     = (state_q == ST_IDLE) && cordic_done;
  assign cordic_start = start_q;
  assign cordic_angle = angle_q;
  assign out_valid    = valid_q;
  assign out_cos      = cos_q;
  assign out_sin      = sin_q;

endmodule

// File: tb/tb_cordic_quadrant_frontend.sv
// Randomised and directed check of the quadrant front end against a
// behavioural core and a rotate-by-quarter-turns reference model.
module tb_cordic_quadrant_frontend;

  localparam int BW = 8;

  typedef struct {
    logic [BW:0] c;
    logic [BW:0] s;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW+1:0] in_angle = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [BW:0]   out_cos;
  logic [BW:0]   out_sin;
  logic          cordic_start;
  logic [BW-1:0] cordic_angle;
  logic          cordic_done;
  logic [BW-1:0] cordic_x = '0;
  logic [BW-1:0] cordic_y = '0;

  logic          core_done = 1'b1;
  logic          hold_low = 1'b0;
  int            core_cnt = 0;
  logic [BW-1:0] core_x_next = '0;
  logic [BW-1:0] core_y_next = '0;

  exp_t          sb_q[$];
  exp_t          mon_e;
  int            checks = 0;
  int            fails = 0;
  logic          inflight = 1'b0;
  logic [BW-1:0] exp_angle = '0;
  logic          prev_stall = 1'b0;
  logic [BW:0]   prev_cos = '0;
  logic [BW:0]   prev_sin = '0;

  assign cordic_done = core_done & ~hold_low;

  always #5 clk = ~clk;

  cordic_quadrant_frontend #(.BIT_WIDTH(BW), .K_UNUSED(0)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_angle     (in_angle),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_cos      (out_cos),
    .out_sin      (out_sin),
    .cordic_start (cordic_start),
    .cordic_angle (cordic_angle),
    .cordic_done  (cordic_done),
    .cordic_x     (cordic_x),
    .cordic_y     (cordic_y)
  );

  // Behavioural core: sees start, drops done on the next edge, raises it 4 later.
  always @(posedge clk) begin
    if (core_cnt == 0) begin
      if (cordic_start && core_done) core_cnt <= 1;
    end else if (core_cnt == 1) begin
      core_done <= 1'b0;
      core_cnt  <= 2;
    end else if (core_cnt == 5) begin
      core_done <= 1'b1;
      core_cnt  <= 0;
      cordic_x  <= core_x_next;
      cordic_y  <= core_y_next;
    end else begin
      core_cnt <= core_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Reference: start from (x, y) and rotate by q quarter turns.
  function automatic exp_t ref_model(input logic [BW+1:0] a, input logic [BW-1:0] x,
                                     input logic [BW-1:0] y);
    int c;
    int s;
    int t;
    int turns;
    exp_t r;
    c = int'(x);
    s = int'(y);
    turns = int'(a[BW+1:BW]);
    for (int k = 0; k < turns; k++) begin
      t = c;
      c = -s;
      s = t;
    end
    r.c = c[BW:0];
    r.s = s[BW:0];
    return r;
  endfunction

  always @(negedge clk) begin
    if (out_valid && prev_stall) begin
      check("hold_cos", 32'(out_cos), 32'(prev_cos));
      check("hold_sin", 32'(out_sin), 32'(prev_sin));
    end
    prev_stall = out_valid && !out_ready;
    prev_cos   = out_cos;
    prev_sin   = out_sin;
    if (out_valid && out_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_out: got cos=0x%0h sin=0x%0h required none", out_cos, out_sin);
      end else begin
        mon_e = sb_q.pop_front();
        if (out_cos !== mon_e.c || out_sin !== mon_e.s) begin
          fails++;
          $display("FAIL result: got cos=0x%0h sin=0x%0h required cos=0x%0h sin=0x%0h",
                   out_cos, out_sin, mon_e.c, mon_e.s);
        end
      end
    end
    if (inflight && !out_valid) check("angle_stable", 32'(cordic_angle), 32'(exp_angle));
  end

  task automatic accept(input logic [BW+1:0] a, input logic [BW-1:0] x,
                        input logic [BW-1:0] y, input bit push, output bit ok);
    int n;
    core_x_next = x;
    core_y_next = y;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_angle = a;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    ok = (n < 100);
    if (!ok) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout: got in_ready=0 required 1 within 100 cycles");
      in_valid = 1'b0;
    end else begin
      if (push) sb_q.push_back(ref_model(a, x, y));
      exp_angle = a[BW-1:0];
      @(posedge clk); #1;
      in_valid = 1'b0;
      inflight = push;
      check("cordic_angle", 32'(cordic_angle), 32'(a[BW-1:0]));
      check("start_after_accept", 32'(cordic_start), 32'd1);
    end
  endtask

  task automatic run_txn(input logic [BW+1:0] a, input logic [BW-1:0] x,
                         input logic [BW-1:0] y, input int hold);
    bit ok;
    int lat;
    accept(a, x, y, 1'b1, ok);
    if (ok) begin
      lat = 0;
      while (!out_valid && lat < 100) begin
        @(posedge clk); #1;
        lat++;
      end
      inflight = 1'b0;
      check("latency", 32'(lat), 32'd7);
      repeat (hold) begin
        @(posedge clk); #1;
        check("valid_held", 32'(out_valid), 32'd1);
      end
      $display("txn angle=0x%03h x=0x%02h y=0x%02h -> cos=0x%03h sin=0x%03h lat=%0d hold=%0d",
               a, x, y, out_cos, out_sin, lat, hold);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("valid_drop", 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish required finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    #2;
    check("rst_start", 32'(cordic_start), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_cos", 32'(out_cos), 32'd0);
    check("rst_sin", 32'(out_sin), 32'd0);
    check("rst_angle", 32'(cordic_angle), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    check("idle_ready", 32'(in_ready), 32'd1);

    run_txn(10'h000, 8'hFF, 8'h00, 0);
    run_txn(10'h140, 8'hEC, 8'h61, 0);
    run_txn(10'h2FF, 8'hFF, 8'hFF, 1);
    run_txn(10'h380, 8'hB5, 8'hB5, 5);
    run_txn(10'h100, 8'h00, 8'h7F, 0);
    run_txn(10'h3FF, 8'h01, 8'hFE, 2);
    run_txn(10'h200, 8'h00, 8'h00, 0);

    // Core busy: request must be neither accepted nor launched.
    @(posedge clk); #1;
    hold_low = 1'b1;
    in_valid = 1'b1;
    in_angle = 10'h155;
    repeat (10) begin
      @(posedge clk); #1;
      check("busy_in_ready", 32'(in_ready), 32'd0);
      check("busy_start", 32'(cordic_start), 32'd0);
    end
    in_valid = 1'b0;
    hold_low = 1'b0;
    $display("txn busy-core stall: 10 cycles without accept");

    // Reset while the core is running abandons the request.
    accept(10'h2A5, 8'h33, 8'h44, 1'b0, ok);
    if (ok) begin
      repeat (4) @(posedge clk);
      #1 reset_n = 1'b0;
      #1;
      check("midrst_start", 32'(cordic_start), 32'd0);
      check("midrst_valid", 32'(out_valid), 32'd0);
      check("midrst_angle", 32'(cordic_angle), 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      repeat (8) begin
        @(posedge clk); #1;
        check("midrst_no_out", 32'(out_valid), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'(cordic_done));
      end
      $display("txn reset mid-busy: request abandoned");
    end
    run_txn(10'h0C3, 8'h9A, 8'h12, 1);

    for (int i = 0; i < 20; i++) begin
      run_txn(10'($urandom_range(0, 1023)), 8'($urandom_range(0, 255)),
              8'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
    end

    repeat (3) @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/cordic_quadrant_frontend.md
CORDIC_QUADRANT_FRONTEND -- requirements
Module: cordic_quadrant_frontend

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 8, giving the CORDIC fraction/magnitude width.
REQ-002 SHALL have parameter K_UNUSED, default 0, reserved and ignored by logic (kept for parameter-list parity with the core).
REQ-003 clk  input  1  single rising-edge clock.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  request accepted when in_valid and in_ready are both high at a clk edge.
REQ-007 in_angle  input  BIT_WIDTH+2  full-circle angle; [BW+1:BW] is quadrant q, [BW-1:0] is fraction f (0 = start of quadrant, 2^BW-1 = just below next).
REQ-008 out_valid  output  1  result held valid.
REQ-009 out_ready  input  1  result consumed when out_valid and out_ready are both high.
REQ-010 out_cos, out_sin  output  BIT_WIDTH+1 each  signed two's-complement results.
REQ-011 cordic_start  output  1  start pulse to the quadrant-I CORDIC core.
REQ-012 cordic_angle  output  BIT_WIDTH  quadrant-I angle to the core.
REQ-013 cordic_done  input  1  core idle/result-valid flag.
REQ-014 cordic_x, cordic_y  input  BIT_WIDTH each  unsigned core outputs (cos f, sin f magnitudes).

Function
REQ-015 SHALL implement FSM states IDLE, LAUNCH, BUSY, HOLD.
REQ-016 in_ready SHALL be 1 only in IDLE with cordic_done=1.
REQ-017 On accept in IDLE: register q and f, drive cordic_angle=f, go to LAUNCH.
REQ-018 cordic_start SHALL be 1 exactly while in LAUNCH and 0 in all other states.
REQ-019 LAUNCH -> BUSY on the first edge where cordic_done=0; otherwise stay in LAUNCH, keeping start high.
REQ-020 BUSY -> HOLD on the first edge where cordic_done=1; on that edge out_cos/out_sin SHALL be loaded from the fold mapping.
REQ-021 Fold mapping (x,y zero-extended): q0 cos=+x, sin=+y; q1 cos=-y, sin=+x; q2 cos=-x, sin=-y; q3 cos=+y, sin=-x.
REQ-022 Negation of any BW-bit magnitude SHALL be exact in BW+1 bits, with no saturation; -0 SHALL yield 0.
REQ-023 out_valid SHALL be 1 exactly in HOLD; out_cos/out_sin SHALL be stable while out_valid=1 and out_ready=0.
REQ-024 HOLD -> IDLE on out_valid and out_ready; a new request SHALL be accepted no earlier than the following edge.
REQ-025 cordic_angle SHALL remain stable from accept until leaving BUSY.
REQ-026 in_valid SHALL be ignored outside IDLE; at most one request SHALL be in flight.
REQ-027 Minimum latency from accept edge to out_valid SHALL be (core latency)+2 cycles.
REQ-028 Quadrant boundaries SHALL be handled as follows: f=0 in q1 gives cos=-y, sin=+x with no special-casing; in_angle=all-ones is legal (q3, f=max).

Reset
REQ-029 On reset_n=0, asynchronously: state=IDLE, cordic_start=0, out_valid=0, out_cos=0, out_sin=0, cordic_angle=0, registered q=0.
REQ-030 Reset mid-operation SHALL abandon the request with no output; after release, in_ready SHALL follow cordic_done.

Structure
REQ-031 Shared package cordic_pkg SHALL hold the state enum (2-bit) and the quadrant enum Q1..Q4 with encoding 0..3.
REQ-032 Fold mapping SHALL be a combinational sub-module cordic_quadrant_fold (inputs q, x, y; outputs cos, sin).
REQ-033 All registers SHALL be in one always_ff block sensitive to posedge clk and negedge reset_n.

Verification (BIT_WIDTH=8, behavioural core: done drops 1 cycle after start, rises 4 cycles later)
REQ-034 in_angle=0x000 with core returning x=0xFF, y=0x00 -> cordic_angle=0x00, out_cos=+255, out_sin=0, out_valid 7 cycles after accept.
REQ-035 in_angle=0x140 with core returning x=0xEC, y=0x61 -> cordic_angle=0x40, out_cos=-97 (0x19F), out_sin=+236.
REQ-036 in_angle=0x2FF with core returning x=0xFF, y=0xFF -> out_cos=-255 (0x101), out_sin=-255.
REQ-037 in_angle=0x380 with core returning x=0xB5, y=0xB5, out_ready held 0 for 5 cycles -> out_valid and data stable, then returns to IDLE one edge after out_ready=1.
REQ-038 reset_n pulsed low during BUSY -> cordic_start=0, out_valid=0 immediately, no result emitted; the next request completes normally.
REQ-039 in_valid=1 with cordic_done=0 -> in_ready=0, no cordic_start for 10 cycles.
